// File: rtl/simd_alu_pkg.sv
// Shared types and helpers for the SIMD adder result path: lane modes, lane sizing, lane saturation limits.
package simd_alu_pkg;

  localparam int SIMD_DATA_W = 256;

  typedef enum logic [1:0] {
    MODE_8  = 2'd0,
    MODE_16 = 2'd1,
    MODE_32 = 2'd2,
    MODE_64 = 2'd3
  } data_mode_e;

  function automatic int lane_bytes(input logic [1:0] mode);
    return 1 << mode;
  endfunction

  // Limits are right-aligned in a 64-bit container, sized to the lane width of the mode.
  function automatic logic [63:0] lane_umax(input logic [1:0] mode);
    return (mode == MODE_64) ? '1 : ((64'h1 << (8 * lane_bytes(mode))) - 64'h1);
  endfunction

  function automatic logic [63:0] lane_smax(input logic [1:0] mode);
    return (64'h1 << (8 * lane_bytes(mode) - 1)) - 64'h1;
  endfunction

  function automatic logic [63:0] lane_smin(input logic [1:0] mode);
    return 64'h1 << (8 * lane_bytes(mode) - 1);
  endfunction

endpackage

// File: rtl/simd_alu_sat_unit.sv
// Combinational per-lane saturation of a SIMD result using byte-granular ovf/udf flags.
// Lanes never straddle a 64-bit boundary, so each byte only looks inside its own 64-bit chunk.
module simd_alu_sat_unit
  import simd_alu_pkg::*;
#(
  parameter int DATA_W = SIMD_DATA_W
) (
  input  logic [DATA_W-1:0]   result,
  input  logic [DATA_W/8-1:0] ovf,
  input  logic [DATA_W/8-1:0] udf,
  input  logic [1:0]          data_mode,
  input  logic                is_signed,
  output logic [DATA_W-1:0]   sat_result
);

  localparam int NCHUNK = DATA_W / 64;

  // Byte b of a chunk: OR-reduce flags over its lane, then pick the saturated byte.
  // ovf wins over udf; only the lane's top byte differs between signed and unsigned limits.
  function automatic logic [7:0] sat_byte(input logic [63:0] d, input logic [7:0] o,
                                          input logic [7:0] u, input logic [1:0] mode,
                                          input logic sgn, input int b);
    int   lb, base;
    logic lo, lu, top;
    lb   = lane_bytes(mode);
    base = b & ~(lb - 1);
    lo   = 1'b0;
    lu   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k >= base && k < base + lb) begin
        lo = lo | o[k];
        lu = lu | u[k];
      end
    end
    top = (b == base + lb - 1);
    if (lo)      sat_byte = (sgn && top) ? 8'h7F : 8'hFF;
    else if (lu) sat_byte = (sgn && top) ? 8'h80 : 8'h00;
    else         sat_byte = d[8*b +: 8];
  endfunction

  for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
    for (genvar b = 0; b < 8; b++) begin : g_byte
      assign sat_result[64*g + 8*b +: 8] =
        sat_byte(result[64*g +: 64], ovf[8*g +: 8], udf[8*g +: 8], data_mode, is_signed, b);
    end
  end

endmodule

// File: rtl/simd_alu_result_stage.sv
// Result FIFO between SIMD ALU issue and writeback, with sticky per-byte flag accumulators.
// Define SIMD_ALU_SAT_EN to saturate flagged lanes before storage; otherwise results wrap.
module simd_alu_result_stage
  import simd_alu_pkg::*;
#(
  parameter int DATA_W     = SIMD_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_result,
  input  logic [DATA_W/8-1:0]           in_ovf,
  input  logic [DATA_W/8-1:0]           in_udf,
  input  logic [1:0]                    in_data_mode,
  input  logic                          in_signed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [DATA_W/8-1:0]           out_ovf,
  output logic [DATA_W/8-1:0]           out_udf,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  input  logic                          clr_sticky,
  output logic [DATA_W/8-1:0]           sticky_ovf,
  output logic [DATA_W/8-1:0]           sticky_udf
);

  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [NB-1:0]     mem_ovf  [FIFO_DEPTH];
  logic [NB-1:0]     mem_udf  [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] wr_data;
  logic              push, pop;

  assign in_ready  = (count != CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef SIMD_ALU_SAT_EN
  simd_alu_sat_unit #(.DATA_W(DATA_W)) u_sat (
    .result     (in_result),
    .ovf        (in_ovf),
    .udf        (in_udf),
    .data_mode  (in_data_mode),
    .is_signed  (in_signed),
    .sat_result (wr_data)
  );
`else
  logic unused_mode;
  assign unused_mode = ^{in_data_mode, in_signed};
  assign wr_data     = in_result;
`endif

  // Storage is not reset; stale entries are hidden by count and output masking.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= wr_data;
      mem_ovf[wr_ptr]  <= in_ovf;
      mem_udf[wr_ptr]  <= in_udf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A clear on the same edge as a push keeps that push's flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_ovf <= '0;
      sticky_udf <= '0;
    end else if (push) begin
      sticky_ovf <= (clr_sticky ? '0 : sticky_ovf) | in_ovf;
      sticky_udf <= (clr_sticky ? '0 : sticky_udf) | in_udf;
    end else if (clr_sticky) begin
      sticky_ovf <= '0;
      sticky_udf <= '0;
    end
  end

  assign out_data = out_valid ? mem_data[rd_ptr] : '0;
  assign out_ovf  = out_valid ? mem_ovf[rd_ptr]  : '0;
  assign out_udf  = out_valid ? mem_udf[rd_ptr]  : '0;

endmodule

// File: tb/tb_simd_alu_result_stage.sv
// Directed bench for simd_alu_result_stage: reset, fill/drain, push+pop, wrap, sticky, saturation.
module tb_simd_alu_result_stage;

  localparam int DATA_W = 256;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_result;
  logic [NB-1:0]     in_ovf, in_udf;
  logic [1:0]        in_data_mode;
  logic              in_signed;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic [NB-1:0]     out_ovf, out_udf;
  logic [2:0]        count;
  logic              clr_sticky;
  logic [NB-1:0]     sticky_ovf, sticky_udf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simd_alu_result_stage #(.DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_ovf       (in_ovf),
    .in_udf       (in_udf),
    .in_data_mode (in_data_mode),
    .in_signed    (in_signed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ovf      (out_ovf),
    .out_udf      (out_udf),
    .count        (count),
    .clr_sticky   (clr_sticky),
    .sticky_ovf   (sticky_ovf),
    .sticky_udf   (sticky_udf)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Push one vector with the consumer stalled, check the head, then pop it.
  task automatic sat_case(input string tag, input logic [1:0] mode, input logic sgn,
                          input logic [DATA_W-1:0] data, input logic [NB-1:0] ovf,
                          input logic [NB-1:0] udf, input logic [DATA_W-1:0] exp);
    in_valid = 1'b1; in_result = data; in_ovf = ovf; in_udf = udf;
    in_data_mode = mode; in_signed = sgn; out_ready = 1'b0;
    step();
    in_valid = 1'b0; in_ovf = '0; in_udf = '0;
    chk(tag, out_data, exp);
    chk("sat_raw_ovf", DATA_W'(out_ovf), DATA_W'(ovf));
    chk("sat_raw_udf", DATA_W'(out_udf), DATA_W'(udf));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] aa;
    logic [DATA_W-1:0] exp_m0, exp_m1, exp_m3;
    aa = {32{8'hAA}};

    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_ovf = '0; in_udf = '0;
    in_data_mode = 2'd0; in_signed = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_out_valid", DATA_W'(out_valid), DATA_W'(0));
    chk("rst_count", DATA_W'(count), DATA_W'(0));
    chk("rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
    chk("rst_sticky_ovf", DATA_W'(sticky_ovf), DATA_W'(0));
    chk("rst_sticky_udf", DATA_W'(sticky_udf), DATA_W'(0));
    chk("rst_out_data", out_data, DATA_W'(0));
    rst_n = 1'b1;
    step();

    // Fill to full with the consumer stalled; the fifth push must be dropped
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_result = DATA_W'(i);
      step();
    end
    chk("full_count", DATA_W'(count), DATA_W'(4));
    chk("full_in_ready", DATA_W'(in_ready), DATA_W'(0));
    in_result = DATA_W'(5);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("drop_count", DATA_W'(count), DATA_W'(4));
    chk("full_head", out_data, DATA_W'(1));
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", out_data, DATA_W'(i));
      step();
    end
    chk("drain_empty", DATA_W'(out_valid), DATA_W'(0));
    chk("drain_zero", out_data, DATA_W'(0));
    out_ready = 1'b0;

    // Simultaneous push and pop at count 2
    in_valid = 1'b1; in_result = DATA_W'(32'h11);
    step();
    in_result = DATA_W'(32'h22);
    step();
    chk("sim_pre_count", DATA_W'(count), DATA_W'(2));
    in_result = aa; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sim_count", DATA_W'(count), DATA_W'(2));
    chk("sim_second", out_data, DATA_W'(32'h22));
    step();
    chk("sim_third", out_data, aa);
    step();
    chk("sim_empty", DATA_W'(out_valid), DATA_W'(0));

    // Ten push/pop pairs: pointers wrap more than twice
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_result = DATA_W'(100 + k); out_ready = 1'b1;
      if (k > 0) begin
        chk("wrap_data", out_data, DATA_W'(100 + k - 1));
        chk("wrap_count", DATA_W'(count), DATA_W'(1));
      end
      step();
    end
    in_valid = 1'b0;
    chk("wrap_last", out_data, DATA_W'(109));
    step();
    chk("wrap_empty", DATA_W'(out_valid), DATA_W'(0));
    out_ready = 1'b0;

    // Reset with entries queued discards them
    in_valid = 1'b1; in_result = DATA_W'(7);
    step(); step();
    in_valid = 1'b0;
    do_reset();
    chk("midrst_valid", DATA_W'(out_valid), DATA_W'(0));
    chk("midrst_count", DATA_W'(count), DATA_W'(0));
    chk("midrst_data", out_data, DATA_W'(0));

    // Sticky accumulation and clear-with-push
    in_valid = 1'b1; in_result = '0; in_ovf = NB'(1);
    step();
    in_ovf = '0; in_udf = NB'(32'h8000_0000);
    step();
    in_valid = 1'b0; in_udf = '0;
    chk("sticky_ovf", DATA_W'(sticky_ovf), DATA_W'(1));
    chk("sticky_udf", DATA_W'(sticky_udf), DATA_W'(32'h8000_0000));
    chk("head_raw_ovf", DATA_W'(out_ovf), DATA_W'(1));
    in_valid = 1'b1; clr_sticky = 1'b1; in_ovf = NB'(4);
    step();
    in_valid = 1'b0; clr_sticky = 1'b0; in_ovf = '0;
    chk("clr_sticky_ovf", DATA_W'(sticky_ovf), DATA_W'(4));
    chk("clr_sticky_udf", DATA_W'(sticky_udf), DATA_W'(0));
    do_reset();

    // Saturation; neighbouring unflagged lanes must pass through unchanged
`ifdef SIMD_ALU_SAT_EN
    exp_m0 = DATA_W'(32'h5AFF);
    exp_m1 = DATA_W'(32'h5678_8000);
    exp_m3 = {128'h0, 64'hAB, 64'h7FFF_FFFF_FFFF_FFFF};
`else
    exp_m0 = DATA_W'(32'h5A05);
    exp_m1 = DATA_W'(32'h5678_1234);
    exp_m3 = {128'h0, 64'hAB, 64'h0123};
`endif
    sat_case("sat_m0_uns_ovf", 2'd0, 1'b0, DATA_W'(32'h5A05), NB'(1), NB'(0), exp_m0);
    sat_case("sat_m1_sgn_udf", 2'd1, 1'b1, DATA_W'(32'h5678_1234), NB'(0), NB'(2), exp_m1);
    sat_case("sat_m3_sgn_ovf", 2'd3, 1'b1, {128'h0, 64'hAB, 64'h0123}, NB'(8'h80), NB'(0), exp_m3);
    chk("sat_end_empty", DATA_W'(out_valid), DATA_W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
